// File: rtl/maxpool_idx.sv
// 2x2 max-pooling with argmax index over a 2*SIZE x 2*SIZE raster-order frame.
// Emits one pooled value and its window position per window, in row-major order.
module maxpool_idx #(
    parameter int SIZE = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pool_start,
    input  logic               in_valid,
    input  logic signed [15:0] in_value,
    output logic signed [15:0] pooled_value,
    output logic [2:0]         history_value,
    output logic               out_valid,
    output logic               pool_end
);

    localparam int EDGE = 2 * SIZE;
    localparam int CW   = (EDGE > 2) ? $clog2(EDGE) : 1;
    localparam int BW   = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      row, col;
    logic [BW-1:0]      slot;
    logic signed [15:0] buf_val [SIZE];
    logic               buf_idx [SIZE];
    logic signed [15:0] temp_val;
    logic               accept, last_pixel;
    logic signed [15:0] cand_val, win_val;
    logic [1:0]         cand_idx, win_idx;

    assign accept     = pool_start && in_valid && (state != DONE);
    assign last_pixel = accept && (row == CW'(EDGE - 1)) && (col == CW'(EDGE - 1));
    assign slot       = BW'(col >> 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pool_start) state_next = RUN;
            RUN: begin
                if (!pool_start)
                    state_next = IDLE;
                else if (last_pixel)
                    state_next = DONE;
            end
            DONE: if (!pool_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strict '>' keeps the lower index on ties, both inside the odd row and against the buffer.
    always_comb begin
        cand_val = temp_val;
        cand_idx = 2'd2;
        if (in_value > temp_val) begin
            cand_val = in_value;
            cand_idx = 2'd3;
        end
        win_val = cand_val;
        win_idx = cand_idx;
        if (buf_val[slot] >= cand_val) begin
            win_val = buf_val[slot];
            win_idx = {1'b0, buf_idx[slot]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row           <= '0;
            col           <= '0;
            pooled_value  <= '0;
            history_value <= '0;
            out_valid     <= 1'b0;
            pool_end      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!pool_start) begin
                row      <= '0;
                col      <= '0;
                pool_end <= 1'b0;
            end else if (accept) begin
                if (col == CW'(EDGE - 1)) begin
                    col <= '0;
                    row <= (row == CW'(EDGE - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (row[0] && col[0]) begin
                    pooled_value  <= win_val;
                    history_value <= {1'b0, win_idx};
                    out_valid     <= 1'b1;
                end
                if (last_pixel)
                    pool_end <= 1'b1;
            end
        end
    end

    // Even rows park the running top-row winner per window; odd rows hold the left pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!row[0]) begin
                if (!col[0]) begin
                    buf_val[slot] <= in_value;
                    buf_idx[slot] <= 1'b0;
                end else if (in_value > buf_val[slot]) begin
                    buf_val[slot] <= in_value;
                    buf_idx[slot] <= 1'b1;
                end
            end else if (!col[0]) begin
                temp_val <= in_value;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_idx.sv
// Directed self-checking bench for maxpool_idx with SIZE=2 (4x4 input frames).
// Expected pooled values and indices are hand-computed per frame.
module tb_maxpool_idx;

    logic               clk;
    logic               reset_n;
    logic               pool_start;
    logic               in_valid;
    logic signed [15:0] in_value;
    logic signed [15:0] pooled_value;
    logic [2:0]         history_value;
    logic               out_valid;
    logic               pool_end;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] frame_pix [16];
    logic signed [15:0] exp_val [4];
    logic [2:0]         exp_hist [4];

    maxpool_idx #(.SIZE(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pool_start    (pool_start),
        .in_valid      (in_valid),
        .in_value      (in_value),
        .pooled_value  (pooled_value),
        .history_value (history_value),
        .out_valid     (out_valid),
        .pool_end      (pool_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of input at a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic signed [15:0] v, input logic vld);
        in_value = v;
        in_valid = vld;
        @(negedge clk);
    endtask

    task automatic runFrame(input int n, input int gap, input string tag);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(frame_pix[i], 1'b1);
            if (((i / 4) % 2 == 1) && (i % 2 == 1)) begin
                checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
                checkOutput({tag, " value"}, 32'(pooled_value), 32'(exp_val[k]));
                checkOutput({tag, " history"}, 32'(history_value), 32'(exp_hist[k]));
                k++;
            end else begin
                checkOutput({tag, " out_valid idle"}, 32'(out_valid), 32'd0);
            end
            checkOutput({tag, " pool_end"}, 32'(pool_end), 32'(i == 15));
            if (gap != 0) begin
                applyStimulus(16'sd0, 1'b0);
                checkOutput({tag, " out_valid gap"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    task automatic startFrame();
        pool_start = 1'b1;
        applyStimulus(16'sd0, 1'b0);
    endtask

    task automatic endFrame();
        pool_start = 1'b0;
        applyStimulus(16'sd0, 1'b0);
        checkOutput("end pool_end clear", 32'(pool_end), 32'd0);
    endtask

    task automatic loadMain();
        frame_pix = '{16'sd1, 16'sd5, 16'sd3, 16'sd2,
                      16'sd4, 16'sd0, 16'sd7, 16'sd9,
                      -16'sd1, -16'sd2, -16'sd3, -16'sd4,
                      -16'sd5, -16'sd6, -16'sd7, -16'sd8};
        exp_val  = '{16'sd5, 16'sd9, -16'sd1, -16'sd3};
        exp_hist = '{3'd1, 3'd3, 3'd0, 3'd0};
    endtask

    initial begin
        reset_n    = 1'b0;
        pool_start = 1'b0;
        in_valid   = 1'b0;
        in_value   = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset value", 32'(pooled_value), 32'd0);
        checkOutput("reset history", 32'(history_value), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset pool_end", 32'(pool_end), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic frame, then extra pixels while the frame is complete.
        loadMain();
        startFrame();
        runFrame(16, 0, "main");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'sd100, 1'b1);
            checkOutput("done out_valid", 32'(out_valid), 32'd0);
            checkOutput("done pool_end", 32'(pool_end), 32'd1);
            checkOutput("done value held", 32'(pooled_value), 32'(-16'sd3));
            checkOutput("done history held", 32'(history_value), 32'd0);
        end
        endFrame();

        // All-equal frame: buffer wins every tie.
        for (int i = 0; i < 16; i++) frame_pix[i] = 16'sd7;
        exp_val  = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        exp_hist = '{3'd0, 3'd0, 3'd0, 3'd0};
        startFrame();
        runFrame(16, 0, "equal");
        endFrame();

        // Maximum at (r+1,c), odd-row tie, and a positive/negative signed comparison.
        frame_pix = '{16'sd0, 16'sd0, 16'sd1, 16'sd1,
                      16'sd10, 16'sd0, 16'sd1, 16'sd20,
                      -16'sd3, -16'sd3, -16'sd9, -16'sd9,
                      -16'sd3, -16'sd3, 16'sd5, 16'sd5};
        exp_val  = '{16'sd10, 16'sd20, -16'sd3, 16'sd5};
        exp_hist = '{3'd2, 3'd3, 3'd0, 3'd2};
        startFrame();
        runFrame(16, 0, "pattern");
        endFrame();

        // Same frame as the first with in_valid toggling.
        loadMain();
        startFrame();
        runFrame(16, 1, "gapped");
        endFrame();

        // Abort after 10 pixels, then a full fresh frame.
        startFrame();
        runFrame(10, 0, "abort");
        pool_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'sd50, 1'b1);
            checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        end
        startFrame();
        runFrame(16, 0, "after abort");
        endFrame();

        // Asynchronous reset after 6 pixels, then a full frame.
        startFrame();
        runFrame(6, 0, "pre reset");
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset value", 32'(pooled_value), 32'd0);
        checkOutput("async reset history", 32'(history_value), 32'd0);
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset pool_end", 32'(pool_end), 32'd0);
        @(negedge clk);
        pool_start = 1'b0;
        reset_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'sd0, 1'b0);
            checkOutput("post reset out_valid", 32'(out_valid), 32'd0);
        end
        startFrame();
        runFrame(16, 0, "after reset");
        endFrame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
